controle_linha: RTL and testbench
=================================

# controle_linha

Synchronous sequencer for the bottling line: drives conveyor motor, fill valve (EV), corking actuator (VE) and alarm from the station sensors. It also owns the cork-stock counter with its refill handshake and the bottle/dozen/batch counters. It sits between the debounced sensor inputs and the display/LED logic and replaces the button-clocked main FSM with a single-clock design.

## Interface
- SEAL_CYCLES, 4, cycles VE stays high per bottle (≥1)
- TIMEOUT, 20'd1000000, watchdog limit in cycles per waiting state (≥2)
- LOW_MARK, 5, cork stock at or below which refill is requested
- REFILL_AMT, 15, corks added per refill acknowledge
- BATCH_DOZENS, 10, dozens per batch
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  line on (level, already toggled upstream)
- pg, ch, ro, cq, eb  in  1 each  bottle at fill station / fill level reached / bottle at cork station / quality pass / bottle at exit; active-high, already synchronized and debounced
- refill_ack  in  1  one-cycle pulse: REFILL_AMT corks loaded
- motor, ev, ve, alarme  out  1 each  actuators
- refill_req  out  1  level, cork stock low
- rolhas  out  7  cork stock, binary 0..99
- garrafas  out  4  accepted bottles in current dozen, 0..11
- duzias  out  7  dozens in current batch, 0..BATCH_DOZENS-1
- duzia_pulse, lote_pulse, reject  out  1 each  one-cycle pulses
- estado  out  3  current state code

## Operation
- States: IDLE=0, MOVE=1, FILL=2, TRANSPORT=3, SEAL=4, INSPECT=5, EXIT=6, ALARM=7.
- Moore outputs: motor=1 in MOVE, TRANSPORT, EXIT; ev=1 in FILL; ve=1 in SEAL while sealing; alarme=1 in ALARM only; all else 0.
- enable=0 in any state: next state IDLE; garrafas and duzias cleared; rolhas retained.
- IDLE→MOVE when enable=1.
- MOVE→FILL on pg; FILL→TRANSPORT on ch; TRANSPORT→SEAL on ro.
- SEAL: if rolhas=0, wait with ve=0. Once rolhas>0, assert ve for exactly SEAL_CYCLES cycles and decrement rolhas once, on the first ve cycle. Then go to INSPECT.
- INSPECT lasts one cycle and samples cq. cq=1 marks the bottle accepted. cq=0 pulses reject and marks it rejected. Next state is always EXIT.
- EXIT→MOVE on eb. On that transition, if the bottle was accepted, garrafas increments.
- garrafas 11→0 pulses duzia_pulse and increments duzias. duzias BATCH_DOZENS-1→0 pulses lote_pulse in the same cycle.
- Watchdog counter clears on every state change. In MOVE, FILL, TRANSPORT, SEAL-wait (rolhas=0) and EXIT, reaching TIMEOUT-1 moves the FSM to ALARM. The counter does not run during active sealing or INSPECT.
- ALARM holds until enable=0, then goes to IDLE.
- Cork stock: next = min(99, rolhas − dec + (refill_ack ? REFILL_AMT : 0)). This formula covers simultaneous decrement and refill. refill_req = (rolhas ≤ LOW_MARK), registered.

## Timing
- Reset values: estado=IDLE, rolhas=0, garrafas=0, duzias=0, watchdog=0, all outputs 0 except refill_req=1 (stock 0 ≤ LOW_MARK), asserted the first cycle after reset.
- Sensor sampled at edge N changes estado at edge N, so outputs change one cycle after the sensor rises. Actuators are decoded from the registered state.
- Sensors ignored outside their waiting state; levels already high on entry are accepted on the next edge (1-cycle dwell minimum).
- Counter updates and pulses occur on the same edge as the transition that causes them; pulses are exactly one cycle wide.
- reset has priority over enable; enable=0 has priority over every sensor and the watchdog.
- Mid-seal enable drop: VE drops next cycle; a cork already decremented is not restored.

## Structure
- Shared package linha_pkg: state encoding constants, MAX_COUNT=99, DOZEN=12.
- One sub-module: estoque_rolhas (saturating 0..99 stock counter with dec, refill_ack, refill_req).
- Everything else lives in controle_linha.

## Test plan
- Reset, enable=1, refill_ack once, full cycle with cq=1 → sequence MOVE,FILL,TRANSPORT,SEAL(ve 4 cycles),INSPECT,EXIT,MOVE; rolhas 15→14; garrafas 0→1.
- 12 accepted bottles → duzia_pulse once, garrafas=0, duzias=1. 120 bottles → lote_pulse once, duzias=0.
- cq=0 at INSPECT → reject pulse, garrafas unchanged, cork still consumed.
- rolhas=0 at SEAL, refill_ack 10 cycles later → ve starts one cycle after the ack and rolhas ends at 14. With TIMEOUT=50 and no ack → ALARM at wait cycle 49, alarme=1; enable=0 → IDLE.
- rolhas=90, refill_ack coincident with the seal decrement → rolhas=99 (saturated); refill_req=0.
- enable=0 during FILL → ev=0 next cycle, IDLE; garrafas and duzias cleared; rolhas retained.

Source files
------------

// File: rtl/linha_pkg.sv
// Shared definitions for the bottling-line sequencer: state encoding,
// counter limits and a small output-decode helper.
package linha_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOVE      = 3'd1,
    S_FILL      = 3'd2,
    S_TRANSPORT = 3'd3,
    S_SEAL      = 3'd4,
    S_INSPECT   = 3'd5,
    S_EXIT      = 3'd6,
    S_ALARM     = 3'd7
  } state_t;

  localparam int MAX_COUNT = 99;
  localparam int DOZEN     = 12;

  // Conveyor runs whenever a bottle is travelling between stations.
  function automatic logic is_moving(input state_t s);
    return (s == S_MOVE) || (s == S_TRANSPORT) || (s == S_EXIT);
  endfunction

endpackage

// File: rtl/estoque_rolhas.sv
// Cork-stock counter: saturates at MAX_COUNT, handles a decrement and a
// refill in the same cycle, and flags low stock one register behind.
module estoque_rolhas
  import linha_pkg::*;
#(
  parameter int LOW_MARK   = 5,
  parameter int REFILL_AMT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dec_i,
  input  logic       refill_ack_i,
  output logic [6:0] rolhas_o,
  output logic       refill_req_o
);

  logic [6:0] rolhas_q, rolhas_d;
  logic       refill_req_q;
  logic [7:0] sum;

  // Nine-bit headroom is unnecessary: 99 + REFILL_AMT stays below 256.
  always_comb begin
    sum = {1'b0, rolhas_q}
        + (refill_ack_i ? 8'(REFILL_AMT) : 8'd0)
        - ((dec_i && (rolhas_q != 7'd0)) ? 8'd1 : 8'd0);
    rolhas_d = (sum > 8'(MAX_COUNT)) ? 7'(MAX_COUNT) : sum[6:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rolhas_q     <= 7'd0;
      refill_req_q <= 1'b1;
    end else begin
      rolhas_q     <= rolhas_d;
      refill_req_q <= (rolhas_d <= 7'(LOW_MARK));
    end
  end

  assign rolhas_o     = rolhas_q;
  assign refill_req_o = refill_req_q;

endmodule

// File: rtl/controle_linha.sv
// Single-clock bottling-line sequencer: station FSM with watchdog, corking
// timer, accepted-bottle / dozen / batch counters and cork-stock control.
module controle_linha
  import linha_pkg::*;
#(
  parameter int SEAL_CYCLES  = 4,
  parameter int TIMEOUT      = 1000000,
  parameter int LOW_MARK     = 5,
  parameter int REFILL_AMT   = 15,
  parameter int BATCH_DOZENS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       pg,
  input  logic       ch,
  input  logic       ro,
  input  logic       cq,
  input  logic       eb,
  input  logic       refill_ack,
  output logic       motor,
  output logic       ev,
  output logic       ve,
  output logic       alarme,
  output logic       refill_req,
  output logic [6:0] rolhas,
  output logic [3:0] garrafas,
  output logic [6:0] duzias,
  output logic       duzia_pulse,
  output logic       lote_pulse,
  output logic       reject,
  output logic [2:0] estado
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam int SC_W = $clog2(SEAL_CYCLES + 1);

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              seal_act_q, seal_act_d;
  logic [SC_W-1:0]   seal_cnt_q, seal_cnt_d;
  logic              accepted_q, accepted_d;
  logic [3:0]        garrafas_q, garrafas_d;
  logic [6:0]        duzias_q, duzias_d;
  logic              duzia_pulse_q, duzia_pulse_d;
  logic              lote_pulse_q, lote_pulse_d;
  logic              reject_q, reject_d;
  logic              wd_run, timeout, dec;

  estoque_rolhas #(
    .LOW_MARK  (LOW_MARK),
    .REFILL_AMT(REFILL_AMT)
  ) u_estoque (
    .clock       (clock),
    .reset       (reset),
    .dec_i       (dec),
    .refill_ack_i(refill_ack),
    .rolhas_o    (rolhas),
    .refill_req_o(refill_req)
  );

  // Watchdog runs only while waiting on a sensor or on cork stock.
  assign wd_run  = (state_q inside {S_MOVE, S_FILL, S_TRANSPORT, S_EXIT})
                || ((state_q == S_SEAL) && !seal_act_q && (rolhas == 7'd0));
  assign timeout = wd_run && (wd_q == WD_W'(TIMEOUT - 1));

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    seal_act_d    = seal_act_q;
    seal_cnt_d    = seal_cnt_q;
    accepted_d    = accepted_q;
    garrafas_d    = garrafas_q;
    duzias_d      = duzias_q;
    duzia_pulse_d = 1'b0;
    lote_pulse_d  = 1'b0;
    reject_d      = 1'b0;
    dec           = 1'b0;

    if (timeout) begin
      state_d = S_ALARM;
    end else begin
      unique case (state_q)
        S_IDLE:      if (enable) state_d = S_MOVE;
        S_MOVE:      if (pg) state_d = S_FILL;
        S_FILL:      if (ch) state_d = S_TRANSPORT;
        S_TRANSPORT: if (ro) state_d = S_SEAL;
        S_SEAL: begin
          if (seal_act_q) begin
            dec = (seal_cnt_q == '0);
            if (seal_cnt_q == SC_W'(SEAL_CYCLES - 1)) begin
              state_d    = S_INSPECT;
              seal_act_d = 1'b0;
              seal_cnt_d = '0;
            end else begin
              seal_cnt_d = seal_cnt_q + SC_W'(1);
            end
          end else if (rolhas != 7'd0) begin
            seal_act_d = 1'b1;
            seal_cnt_d = '0;
          end
        end
        S_INSPECT: begin
          accepted_d = cq;
          reject_d   = !cq;
          state_d    = S_EXIT;
        end
        S_EXIT: begin
          if (eb) begin
            state_d = S_MOVE;
            if (accepted_q) begin
              if (garrafas_q == 4'(DOZEN - 1)) begin
                garrafas_d    = 4'd0;
                duzia_pulse_d = 1'b1;
                if (duzias_q == 7'(BATCH_DOZENS - 1)) begin
                  duzias_d     = 7'd0;
                  lote_pulse_d = 1'b1;
                end else begin
                  duzias_d = duzias_q + 7'd1;
                end
              end else begin
                garrafas_d = garrafas_q + 4'd1;
              end
            end
          end
        end
        S_ALARM: ;
        default: state_d = S_IDLE;
      endcase
    end

    // Line switched off overrides sensors and watchdog; stock is kept.
    if (!enable) begin
      state_d       = S_IDLE;
      seal_act_d    = 1'b0;
      seal_cnt_d    = '0;
      garrafas_d    = 4'd0;
      duzias_d      = 7'd0;
      duzia_pulse_d = 1'b0;
      lote_pulse_d  = 1'b0;
      reject_d      = 1'b0;
    end

    if (state_d != state_q) wd_d = '0;
    else if (wd_run)        wd_d = wd_q + WD_W'(1);
    else                    wd_d = wd_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wd_q          <= '0;
      seal_act_q    <= 1'b0;
      seal_cnt_q    <= '0;
      accepted_q    <= 1'b0;
      garrafas_q    <= 4'd0;
      duzias_q      <= 7'd0;
      duzia_pulse_q <= 1'b0;
      lote_pulse_q  <= 1'b0;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      seal_act_q    <= seal_act_d;
      seal_cnt_q    <= seal_cnt_d;
      accepted_q    <= accepted_d;
      garrafas_q    <= garrafas_d;
      duzias_q      <= duzias_d;
      duzia_pulse_q <= duzia_pulse_d;
      lote_pulse_q  <= lote_pulse_d;
      reject_q      <= reject_d;
    end
  end

  assign motor       = is_moving(state_q);
  assign ev          = (state_q == S_FILL);
  assign ve          = (state_q == S_SEAL) && seal_act_q;
  assign alarme      = (state_q == S_ALARM);
  assign garrafas    = garrafas_q;
  assign duzias      = duzias_q;
  assign duzia_pulse = duzia_pulse_q;
  assign lote_pulse  = lote_pulse_q;
  assign reject      = reject_q;
  assign estado      = state_q;

endmodule

// File: tb/tb_controle_linha.sv
// Directed bench for controle_linha: full bottle cycles, dozen/batch rollover,
// reject, cork-starved seal, watchdog alarm, stock saturation, line stop.
module tb_controle_linha;

  localparam int SEAL_CYCLES  = 4;
  localparam int TIMEOUT      = 50;
  localparam int LOW_MARK     = 5;
  localparam int REFILL_AMT   = 15;
  localparam int BATCH_DOZENS = 10;

  logic       clock = 1'b0;
  logic       reset, enable, pg, ch, ro, cq, eb, refill_ack;
  logic       motor, ev, ve, alarme, refill_req;
  logic [6:0] rolhas;
  logic [3:0] garrafas;
  logic [6:0] duzias;
  logic       duzia_pulse, lote_pulse, reject;
  logic [2:0] estado;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_rol, exp_garr, exp_duz;
  int n_duz_pulse, n_lote_pulse;

  controle_linha #(
    .SEAL_CYCLES (SEAL_CYCLES),
    .TIMEOUT     (TIMEOUT),
    .LOW_MARK    (LOW_MARK),
    .REFILL_AMT  (REFILL_AMT),
    .BATCH_DOZENS(BATCH_DOZENS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .pg         (pg),
    .ch         (ch),
    .ro         (ro),
    .cq         (cq),
    .eb         (eb),
    .refill_ack (refill_ack),
    .motor      (motor),
    .ev         (ev),
    .ve         (ve),
    .alarme     (alarme),
    .refill_req (refill_req),
    .rolhas     (rolhas),
    .garrafas   (garrafas),
    .duzias     (duzias),
    .duzia_pulse(duzia_pulse),
    .lote_pulse (lote_pulse),
    .reject     (reject),
    .estado     (estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0;
    pg = 1'b0; ch = 1'b0; ro = 1'b0; cq = 1'b0; eb = 1'b0; refill_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_rol = 0; exp_garr = 0; exp_duz = 0;
  endtask

  // Raise one sensor for a single edge and check the resulting state.
  task automatic sensor_step(input int s, input int exp_state, input string tag);
    case (s)
      0: pg = 1'b1;
      1: ch = 1'b1;
      2: ro = 1'b1;
      default: eb = 1'b1;
    endcase
    tick();
    pg = 1'b0; ch = 1'b0; ro = 1'b0; eb = 1'b0;
    check(tag, int'(estado), exp_state);
  endtask

  task automatic to_seal();
    sensor_step(0, 2, "move_to_fill");
    check("ev_in_fill", int'(ev), 1);
    sensor_step(1, 3, "fill_to_transport");
    check("motor_in_transport", int'(motor), 1);
    sensor_step(2, 4, "transport_to_seal");
    check("ve_low_on_seal_entry", int'(ve), 0);
  endtask

  // Finish the bottle from somewhere inside SEAL; caller sets exp_rol.
  task automatic finish_bottle(input logic q, input int exp_ve);
    int ve_cnt = 0;
    int n = 0;
    bit exp_dp = 1'b0;
    bit exp_lp = 1'b0;
    while (estado == 3'd4 && n < 200) begin
      if (ve) ve_cnt++;
      tick();
      n++;
    end
    check("ve_cycles", ve_cnt, exp_ve);
    check("inspect_state", int'(estado), 5);
    check("rolhas_after_seal", int'(rolhas), exp_rol);
    cq = q;
    tick();
    cq = 1'b0;
    check("exit_state", int'(estado), 6);
    check("reject_pulse", int'(reject), q ? 0 : 1);
    if (q) begin
      exp_garr++;
      if (exp_garr == 12) begin
        exp_garr = 0; exp_duz++; exp_dp = 1'b1;
        if (exp_duz == BATCH_DOZENS) begin
          exp_duz = 0; exp_lp = 1'b1;
        end
      end
    end
    sensor_step(3, 1, "exit_to_move");
    check("garrafas", int'(garrafas), exp_garr);
    check("duzias", int'(duzias), exp_duz);
    check("duzia_pulse", int'(duzia_pulse), int'(exp_dp));
    check("lote_pulse", int'(lote_pulse), int'(exp_lp));
    n_duz_pulse += int'(duzia_pulse);
    n_lote_pulse += int'(lote_pulse);
  endtask

  task automatic run_bottle(input logic q);
    if (exp_rol <= LOW_MARK) begin
      refill_ack = 1'b1;
      tick();
      refill_ack = 1'b0;
      exp_rol = (exp_rol + REFILL_AMT > 99) ? 99 : exp_rol + REFILL_AMT;
    end
    to_seal();
    exp_rol--;
    finish_bottle(q, SEAL_CYCLES);
  endtask

  initial begin
    int n;
    do_reset();
    check("rst_estado", int'(estado), 0);
    check("rst_rolhas", int'(rolhas), 0);
    check("rst_refill_req", int'(refill_req), 1);
    check("rst_motor", int'(motor), 0);
    check("rst_ve", int'(ve), 0);
    check("rst_alarme", int'(alarme), 0);
    check("rst_garrafas", int'(garrafas), 0);
    check("rst_duzias", int'(duzias), 0);

    // First refill, then one accepted bottle.
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    exp_rol = 15;
    check("refill_rolhas", int'(rolhas), 15);
    check("refill_req_cleared", int'(refill_req), 0);
    check("idle_without_enable", int'(estado), 0);
    enable = 1'b1;
    tick();
    check("idle_to_move", int'(estado), 1);
    check("motor_in_move", int'(motor), 1);
    to_seal();
    exp_rol = 14;
    finish_bottle(1'b1, SEAL_CYCLES);

    // Rejected bottle still consumes a cork.
    to_seal();
    exp_rol = 13;
    finish_bottle(1'b0, SEAL_CYCLES);

    // 119 more accepted bottles: 120 total, ten dozens, one batch.
    n_duz_pulse = 0;
    n_lote_pulse = 0;
    for (int i = 0; i < 119; i++) run_bottle(1'b1);
    check("dozen_pulse_total", n_duz_pulse, 10);
    check("batch_pulse_total", n_lote_pulse, 1);
    check("batch_end_duzias", int'(duzias), 0);
    check("batch_end_garrafas", int'(garrafas), 0);
    tick();
    check("lote_pulse_one_cycle", int'(lote_pulse), 0);
    check("duzia_pulse_one_cycle", int'(duzia_pulse), 0);

    // Empty stock at SEAL, refill arrives 10 cycles later.
    do_reset();
    enable = 1'b1;
    tick();
    to_seal();
    repeat (10) tick();
    check("starved_stays_seal", int'(estado), 4);
    check("starved_ve_low", int'(ve), 0);
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    check("starved_ack_rolhas", int'(rolhas), 15);
    check("starved_ve_not_yet", int'(ve), 0);
    tick();
    check("starved_ve_starts", int'(ve), 1);
    exp_rol = 14;
    finish_bottle(1'b1, SEAL_CYCLES);

    // Empty stock and no refill: watchdog trips after 50 cycles in SEAL.
    do_reset();
    enable = 1'b1;
    tick();
    to_seal();
    n = 0;
    while (estado == 3'd4 && n < 100) begin
      tick();
      n++;
    end
    check("watchdog_cycles", n, TIMEOUT);
    check("alarm_state", int'(estado), 7);
    check("alarme_high", int'(alarme), 1);
    check("alarm_motor_off", int'(motor), 0);
    tick();
    check("alarm_holds", int'(estado), 7);
    enable = 1'b0;
    tick();
    check("alarm_to_idle", int'(estado), 0);
    check("alarme_cleared", int'(alarme), 0);

    // Stock 90, refill coincident with the seal decrement: saturates at 99.
    do_reset();
    refill_ack = 1'b1;
    repeat (6) tick();
    refill_ack = 1'b0;
    check("stock_90", int'(rolhas), 90);
    check("stock_90_no_req", int'(refill_req), 0);
    enable = 1'b1;
    tick();
    to_seal();
    tick();
    check("sat_first_ve", int'(ve), 1);
    refill_ack = 1'b1;
    tick();
    refill_ack = 1'b0;
    check("sat_rolhas", int'(rolhas), 99);
    check("sat_refill_req", int'(refill_req), 0);
    exp_rol = 99;
    finish_bottle(1'b1, SEAL_CYCLES - 1);

    // Twelve more so both counters are non-zero, then stop during FILL.
    for (int i = 0; i < 12; i++) run_bottle(1'b1);
    check("pre_stop_garrafas", int'(garrafas), 1);
    check("pre_stop_duzias", int'(duzias), 1);
    sensor_step(0, 2, "stop_fill_entry");
    check("stop_ev_before", int'(ev), 1);
    enable = 1'b0;
    tick();
    check("stop_idle", int'(estado), 0);
    check("stop_ev_off", int'(ev), 0);
    check("stop_garrafas_cleared", int'(garrafas), 0);
    check("stop_duzias_cleared", int'(duzias), 0);
    check("stop_rolhas_kept", int'(rolhas), 87);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
